// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a framed image (LEN_LO, LEN_HI, payload, CSUM)
// over a valid/ready byte interface and writes the payload little-endian into instruction memory.
module imem_loader #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_run,
  output logic              err_len,
  output logic              err_csum,
  output logic [15:0]       byte_count,
  output logic [2:0]        dbg_state_o
);

  // Handshake: a byte transfers on a rising edge where in_valid & in_ready are both high;
  // in_ready depends only on the current state, never on in_valid.

  typedef enum logic [2:0] {
    S_HDR_LO = 3'd0,
    S_HDR_HI = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_e;

  localparam logic [16:0] MAX_LEN = 17'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [15:0]       byte_count_q, byte_count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              err_len_q, err_len_d;
  logic              err_csum_q, err_csum_d;

  logic        xfer;
  logic [15:0] len_full;
  logic        len_bad;
  logic        last_byte;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_HDR_LO;
      len_q        <= '0;
      sum_q        <= '0;
      byte_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_len_q    <= 1'b0;
      err_csum_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      byte_count_q <= byte_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_len_q    <= err_len_d;
      err_csum_q   <= err_csum_d;
    end
  end

  always_comb begin
    in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
               (state_q == S_DATA)   || (state_q == S_CSUM);
  end

  assign xfer      = in_valid && in_ready;
  // Length is checked against the byte arriving this cycle, before it is registered.
  assign len_full  = {in_data, len_q[7:0]};
  assign len_bad   = ({1'b0, len_full} > MAX_LEN) || (len_full[1:0] != 2'b00);
  assign last_byte = ((byte_count_q + 16'd1) == len_q);

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    byte_count_d = byte_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_len_d    = err_len_q;
    err_csum_d   = err_csum_q;

    if (load_start) begin
      // Restart wins over a same-cycle transfer; that byte is dropped.
      state_d      = S_HDR_LO;
      len_d        = '0;
      sum_d        = '0;
      byte_count_d = '0;
      err_len_d    = 1'b0;
      err_csum_d   = 1'b0;
    end else if (xfer) begin
      unique case (state_q)
        S_HDR_LO: begin
          len_d[7:0] = in_data;
          state_d    = S_HDR_HI;
        end
        S_HDR_HI: begin
          len_d[15:8] = in_data;
          if (len_bad) begin
            err_len_d = 1'b1;
            state_d   = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          mem_we_d     = 1'b1;
          mem_addr_d   = byte_count_q[ADDR_W-1:0];
          mem_wdata_d  = in_data;
          sum_d        = sum_q + in_data;
          byte_count_d = byte_count_q + 16'd1;
          if (last_byte) begin
            state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (in_data == sum_q) begin
            state_d = S_DONE;
          end else begin
            err_csum_d = 1'b1;
            state_d    = S_ERROR;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_run     = (state_q == S_DONE);
  assign err_len     = err_len_q;
  assign err_csum    = err_csum_q;
  assign byte_count  = byte_count_q;
  assign dbg_state_o = state_q;

endmodule
